// File: rtl/clock_sequencer.sv
// ============================================================================
//  Module   : clock_sequencer
//  Purpose  : Post-MMCM reset sequencer and 8/4 MHz clock-enable generator
//             for the 56 MHz domain. Synchronises the MMCM lock flag, holds
//             the core in reset for HOLD cycles after lock, re-enters the
//             hold on a soft-reset request, and produces single-cycle
//             enable strobes in place of derived clocks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_sequencer #(
    parameter int HOLD = 1024,  // cycles spent in HOLD before ready rises
    parameter int DIV  = 7      // 8 MHz divide ratio from 56 MHz
) (
    input  logic clock,
    input  logic reset,         // asynchronous, active-low
    input  logic locked,        // MMCM lock flag, asynchronous to clock
    input  logic request,       // soft-reset pulse, synchronous to clock
    output logic ready,
    output logic ce8p,
    output logic ce8n,
    output logic ce4p,
    output logic ce4n
);

    localparam int HW = $clog2(HOLD) + 1;
    localparam int PW = $clog2(2 * DIV);

    localparam logic [HW-1:0] HC_LAST = HW'(HOLD - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * DIV - 1);
    localparam logic [PW-1:0] PH_DIV  = PW'(DIV);
    localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          s1;
    logic          s2;
    logic [HW-1:0] hc;
    logic [HW-1:0] hc_nx;
    logic [PW-1:0] ph;
    logic [PW-1:0] ph_nx;
    logic [PW-1:0] ph_mod;
    logic          active;
    logic          ready_nx;
    logic          ce8p_nx;
    logic          ce8n_nx;
    logic          ce4p_nx;
    logic          ce4n_nx;

    // Two-flop synchroniser for the asynchronous lock flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= locked;
            s2 <= s1;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_WAIT;
            hc    <= '0;
            ph    <= '0;
            ready <= 1'b0;
            ce8p  <= 1'b0;
            ce8n  <= 1'b0;
            ce4p  <= 1'b0;
            ce4n  <= 1'b0;
        end else begin
            state <= state_nx;
            hc    <= hc_nx;
            ph    <= ph_nx;
            ready <= ready_nx;
            ce8p  <= ce8p_nx;
            ce8n  <= ce8n_nx;
            ce4p  <= ce4p_nx;
            ce4n  <= ce4n_nx;
        end
    end

    // Next-state, hold counter, phase counter and strobe decode
    always_comb begin
        state_nx = state;
        hc_nx    = hc;

        case (state)
            ST_WAIT: begin
                hc_nx = '0;
                if (s2) begin
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Lock loss outranks everything; a request outranks the
                // terminal count so a late request still restarts the hold.
                if (!s2) begin
                    state_nx = ST_WAIT;
                    hc_nx    = '0;
                end else if (request) begin
                    hc_nx = '0;
                end else if (hc == HC_LAST) begin
                    state_nx = ST_RUN;
                    hc_nx    = '0;
                end else begin
                    hc_nx = hc + 1'b1;
                end
            end
            ST_RUN: begin
                if (!s2) begin
                    state_nx = ST_WAIT;
                    hc_nx    = '0;
                end else if (request) begin
                    state_nx = ST_HOLD;
                    hc_nx    = '0;
                end
            end
            default: begin
                state_nx = ST_WAIT;
                hc_nx    = '0;
            end
        endcase

        // Strobes and phase only run while in HOLD/RUN and not about to
        // drop to WAIT, so everything is already quiet on WAIT entry.
        active = (state != ST_WAIT) && (state_nx != ST_WAIT);

        if (!active) begin
            ph_nx = '0;
        end else if (ph == PH_LAST) begin
            ph_nx = '0;
        end else begin
            ph_nx = ph + 1'b1;
        end

        ph_mod   = (ph >= PH_DIV) ? (ph - PH_DIV) : ph;
        ce8p_nx  = active && (ph_mod == '0);
        ce8n_nx  = active && (ph_mod == PH_HALF);
        ce4p_nx  = active && (ph == '0);
        ce4n_nx  = active && (ph == PH_DIV);
        ready_nx = (state_nx == ST_RUN);
    end

endmodule

`default_nettype wire

// File: tb/tb_clock_sequencer.sv
// ============================================================================
//  Module   : tb_clock_sequencer
//  Purpose  : Self-checking bench for clock_sequencer (HOLD=16, DIV=7).
//             Expected output vectors are queued per cycle as stimulus is
//             issued; a negedge monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_sequencer;

    localparam int HOLD = 16;
    localparam int DIV  = 7;

    logic clock   = 1'b0;
    logic reset   = 1'b0;
    logic locked  = 1'b1;
    logic request = 1'b0;
    logic ready;
    logic ce8p;
    logic ce8n;
    logic ce4p;
    logic ce4n;

    // Edge 1 is the first edge that samples locked=1 with reset released
    int cyc      = -4;
    int checks   = 0;
    int failures = 0;
    int n8p = 0, n8n = 0, n4p = 0, n4n = 0;

    typedef struct {
        int         cyc;
        logic [4:0] vec;   // {ready, ce8p, ce8n, ce4p, ce4n}
    } exp_t;

    exp_t q[$];

    clock_sequencer #(
        .HOLD (HOLD),
        .DIV  (DIV)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .locked  (locked),
        .request (request),
        .ready   (ready),
        .ce8p    (ce8p),
        .ce8n    (ce8n),
        .ce4p    (ce4p),
        .ce4n    (ce4n)
    );

    // 56 MHz stand-in clock
    always #5 clock = ~clock;

    // Edge counter
    always @(posedge clock) cyc <= cyc + 1;

    // Hand-derived timeline of the whole run, indexed by edge number.
    // ready windows: lock at 1 -> 19; request 100 -> 116; requests 210/221/237
    // -> 253; lock lost at 280 -> WAIT at 282; async reset at 295, released
    // so edge 300 relocks -> 318. Strobe anchors (ce8p+ce4p): 4, 288, 303.
    function automatic logic [4:0] exp_vec(input int e);
        logic       r;
        logic [3:0] s;
        int         a;
        int         d;
        r = (e >= 19 && e <= 99) || (e >= 116 && e <= 209) ||
            (e >= 253 && e <= 281) || (e >= 318);
        a = -1;
        if (e >= 4 && e <= 281)        a = 4;
        else if (e >= 288 && e <= 294) a = 288;
        else if (e >= 303)             a = 303;
        s = 4'b0000;
        if (a >= 0) begin
            d    = (e - a) % 14;
            s[3] = (d == 0) || (d == 7);    // ce8p
            s[2] = (d == 3) || (d == 10);   // ce8n
            s[1] = (d == 0);                // ce4p
            s[0] = (d == 7);                // ce4n
        end
        return {r, s};
    endfunction

    task automatic plan(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) begin
            exp_t e;
            e.cyc = c;
            e.vec = exp_vec(c);
            q.push_back(e);
        end
    endtask

    task automatic wait_neg(input int n);
        do @(negedge clock); while (cyc != n);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the expected vector for the current edge and compares
    always @(negedge clock) begin
        logic [4:0] act;
        exp_t       e;
        act = {ready, ce8p, ce8n, ce4p, ce4n};
        if (cyc >= 20 && cyc <= 159) begin
            n8p = n8p + int'(ce8p);
            n8n = n8n + int'(ce8n);
            n4p = n4p + int'(ce4p);
            n4n = n4n + int'(ce4n);
        end
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL missed_sample cyc=%0d actual_cyc=%0d required_cyc=%0d",
                         cyc, cyc, e.cyc);
            end else if (act !== e.vec) begin
                failures++;
                $display("FAIL outputs cyc=%0d actual=%b required=%b (ready,ce8p,ce8n,ce4p,ce4n)",
                         cyc, act, e.vec);
            end
        end
    end

    // Stimulus
    initial begin
        // Reset held low with locked already high, then release
        plan(-2, 99);
        wait_neg(0);
        reset = 1'b1;

        // Soft reset in RUN, sampled at edge 100
        wait_neg(99);
        plan(100, 209);
        request = 1'b1;
        wait_neg(100);
        request = 1'b0;

        // Strobe counts over edges 20..159 (140 cycles)
        wait_neg(160);
        check_int("count_ce8p", n8p, 20);
        check_int("count_ce8n", n8n, 20);
        check_int("count_ce4p", n4p, 10);
        check_int("count_ce4n", n4n, 10);

        // Request in RUN, then in HOLD at hc=10 and at hc=HOLD-1
        wait_neg(209);
        plan(210, 279);
        request = 1'b1;
        wait_neg(210);
        request = 1'b0;
        wait_neg(220);
        request = 1'b1;
        wait_neg(221);
        request = 1'b0;
        wait_neg(236);
        request = 1'b1;
        wait_neg(237);
        request = 1'b0;

        // Lock lost for 5 cycles; a request coincides with the WAIT entry
        wait_neg(279);
        plan(280, 294);
        locked = 1'b0;
        wait_neg(281);
        request = 1'b1;
        wait_neg(282);
        request = 1'b0;
        wait_neg(284);
        locked = 1'b1;

        // Asynchronous reset between edges in the middle of HOLD
        wait_neg(294);
        @(posedge clock);
        #2;
        plan(295, 360);
        reset = 1'b0;
        wait_neg(299);
        reset = 1'b1;

        wait_neg(361);
        check_int("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
